// File: rtl/uart_tx.sv
// UART transmitter: serialises one 5-8 bit character per request as start bit,
// data LSB first, optional parity and 1 or 2 stop bits, timed by an oversample tick.
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_tick,
  input  logic        start_tx_i,
  input  logic [31:0] tx_data_i,
  input  logic [1:0]  data_bit_num_i,
  input  logic        parity_en_i,
  input  logic        parity_type_i,
  input  logic        stop_bit_num_i,
  input  logic        cts_n,
  output logic        tx,
  output logic        tx_busy_o,
  output logic        tx_done_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  tx_state_e        state, state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [1:0]       data_bits;
  logic             parity_en;
  logic             stop_two;
  logic             parity_bit;

  logic       accept;
  logic       bit_end;
  logic       last_data;
  logic       last_stop;
  logic [7:0] data_mask;
  logic       new_parity;
  logic       unused_data;

  assign unused_data = ^tx_data_i[31:8];

  // Acceptance also waits out the tx_done_o cycle (busy still high), which gives
  // the register block one clock to drop its level request after done.
  assign accept    = (state == TX_IDLE) && !tx_busy_o && start_tx_i && !cts_n;
  assign bit_end   = tx_tick && (tick_cnt == CNT_W'(OVERSAMPLE - 1));
  assign last_data = (bit_cnt == {1'b1, data_bits});
  assign last_stop = !stop_two || bit_cnt[0];

  assign data_mask  = 8'hff >> (3'd3 - {1'b0, data_bit_num_i});
  assign new_parity = parity_type_i ? ^(tx_data_i[7:0] & data_mask)
                                    : ~^(tx_data_i[7:0] & data_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_next;
  end

  // NOTE: next state is defaulted to the current state before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:   if (accept) state_next = TX_START;
      TX_START:  if (bit_end) state_next = TX_DATA;
      TX_DATA:   if (bit_end && last_data) state_next = parity_en ? TX_PARITY : TX_STOP;
      TX_PARITY: if (bit_end) state_next = TX_STOP;
      TX_STOP:   if (bit_end && last_stop) state_next = TX_IDLE;
      default:   state_next = TX_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_bits  <= '0;
      parity_en  <= 1'b0;
      stop_two   <= 1'b0;
      parity_bit <= 1'b0;
    end else if (accept) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= tx_data_i[7:0];
      data_bits  <= data_bit_num_i;
      parity_en  <= parity_en_i;
      stop_two   <= stop_bit_num_i;
      parity_bit <= new_parity;
    end else if (state != TX_IDLE && tx_tick) begin
      tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      if (bit_end) begin
        case (state)
          TX_DATA: begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= last_data ? 3'd0 : bit_cnt + 3'd1;
          end
          TX_STOP: bit_cnt <= bit_cnt + 3'd1;
          default: ;
        endcase
      end
    end
  end

  // Outputs are registered from the state, so each lags its state change by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx        <= 1'b1;
      tx_busy_o <= 1'b0;
      tx_done_o <= 1'b0;
    end else begin
      tx_busy_o <= (state != TX_IDLE);
      tx_done_o <= (state == TX_IDLE) && tx_busy_o;
      case (state)
        TX_START:  tx <= 1'b0;
        TX_DATA:   tx <= shift_reg[0];
        TX_PARITY: tx <= parity_bit;
        default:   tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor decodes
// the serial line by counting ticks and compares bit pattern and frame length.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_tick = 1'b0;
  logic        start_tx_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic [1:0]  data_bit_num_i = 2'd3;
  logic        parity_en_i = 1'b0;
  logic        parity_type_i = 1'b0;
  logic        stop_bit_num_i = 1'b0;
  logic        cts_n = 1'b1;
  logic        tx;
  logic        tx_busy_o;
  logic        tx_done_o;

  uart_tx #(.OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_tick        (tx_tick),
    .start_tx_i     (start_tx_i),
    .tx_data_i      (tx_data_i),
    .data_bit_num_i (data_bit_num_i),
    .parity_en_i    (parity_en_i),
    .parity_type_i  (parity_type_i),
    .stop_bit_num_i (stop_bit_num_i),
    .cts_n          (cts_n),
    .tx             (tx),
    .tx_busy_o      (tx_busy_o),
    .tx_done_o      (tx_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;   // bit k = k-th line bit of the frame, start bit first
    int          ticks;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // One tick every 4 clocks, driven just after the edge so it is stable at negedge.
  initial begin
    int div = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Monitor: counts ticks the DUT counts (tick at edge P while busy was high),
  // samples tx mid-bit, and compares against the queue on tx_done_o.
  initial begin
    bit          active = 1'b0;
    bit          tick_prev = 1'b0;
    int          cnt = 0;
    int          nsamp = 0;
    logic [15:0] got = '0;
    frame_t      f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (!active && tx_busy_o) begin
          active = 1'b1;
          cnt = 0;
          nsamp = 0;
          got = '0;
        end
        if (active) begin
          if (tick_prev && tx_busy_o) begin
            cnt++;
            if (cnt % 16 == 8 && nsamp < 16) begin
              got[nsamp] = tx;
              nsamp++;
            end
          end
          if (tx_done_o) begin
            active = 1'b0;
            check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              f = exp_q.pop_front();
              check("frame_bits", 32'(got), 32'(f.bits));
              check("frame_ticks", 32'(cnt), 32'(f.ticks));
              check("busy_low_at_done", 32'(tx_busy_o), 32'd0);
            end
          end
        end else if (tx_done_o) begin
          check("stray_done", 32'(tx_done_o), 32'd0);
        end
      end
      tick_prev = tx_tick;
    end
  end

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      seen = tx_done_o;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic send(input string name, input logic [1:0] nb, input bit pen,
                      input bit ptype, input bit stop2, input logic [31:0] data,
                      input logic [15:0] bits, input int ticks);
    data_bit_num_i = nb;
    parity_en_i    = pen;
    parity_type_i  = ptype;
    stop_bit_num_i = stop2;
    tx_data_i      = data;
    exp_q.push_back('{bits, ticks});
    cts_n      = 1'b0;
    start_tx_i = 1'b1;
    wait_done(name);
    start_tx_i = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    bit bad = 1'b0;
    int dones = 0;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy_o), 32'd0);
    check("reset_done", 32'(tx_done_o), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: 0, 1,0,1,0,0,1,0,1, 1
    send("8n1_a5", 2'd3, 1'b0, 1'b0, 1'b0, 32'h0000_00a5, 16'h034a, 160);
    // 5E1 0x13: 0, 1,1,0,0,1, par 1, 1
    send("5e1_13", 2'd0, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 16'h00e6, 128);
    // 5O1 0x13: parity bit 0
    send("5o1_13", 2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 16'h00a6, 128);
    // 7O2 0x7F: seven 1s, parity 0, two stop bits
    send("7o2_7f", 2'd2, 1'b1, 1'b0, 1'b1, 32'h0000_007f, 16'h06fe, 176);

    // Flow control: request held while cts_n high must not start a frame.
    data_bit_num_i = 2'd3;
    parity_en_i    = 1'b0;
    stop_bit_num_i = 1'b0;
    tx_data_i      = 32'h0000_003c;
    cts_n          = 1'b1;
    start_tx_i     = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy_o !== 1'b0) bad = 1'b1;
    end
    check("cts_blocks_frame", 32'(bad), 32'd0);
    exp_q.push_back('{16'h0278, 160});
    cts_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cts_start_tx_low", 32'(tx), 32'd0);
    check("cts_start_busy", 32'(tx_busy_o), 32'd1);
    wait_ticks(50);
    cts_n = 1'b1;
    wait_done("cts_mid_frame");
    start_tx_i = 1'b0;
    cts_n = 1'b0;
    repeat (8) @(negedge clk);

    // Mid-frame changes: 6E1 of 0xAD (low six bits 0x2D, four ones -> parity 0).
    data_bit_num_i = 2'd1;
    parity_en_i    = 1'b1;
    parity_type_i  = 1'b1;
    tx_data_i      = 32'h0000_00ad;
    exp_q.push_back('{16'h015a, 144});
    start_tx_i = 1'b1;
    wait_ticks(2);
    start_tx_i = 1'b0;
    wait_ticks(40);
    data_bit_num_i = 2'd3;
    parity_en_i    = 1'b0;
    tx_data_i      = 32'h0000_00ff;
    wait_ticks(10);
    start_tx_i = 1'b1;
    @(negedge clk);
    start_tx_i = 1'b0;
    wait_done("mid_frame_change");
    repeat (300) @(negedge clk);
    check("no_extra_frame_busy", 32'(tx_busy_o), 32'd0);

    // Reset mid-frame: abandoned frame produces no done.
    data_bit_num_i = 2'd3;
    parity_en_i    = 1'b0;
    tx_data_i      = 32'h0000_00f0;
    start_tx_i     = 1'b1;
    wait_ticks(40);
    check("pre_reset_busy", 32'(tx_busy_o), 32'd1);
    rst_n = 1'b0;
    start_tx_i = 1'b0;
    #1;
    check("reset_mid_tx", 32'(tx), 32'd1);
    check("reset_mid_busy", 32'(tx_busy_o), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (tx_done_o) dones++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_done_o) dones++;
    end
    check("reset_mid_no_done", 32'(dones), 32'd0);
    send("8n1_55_after_reset", 2'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0055, 16'h02aa, 160);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the APB-UART peripheral; the transmit-side counterpart of the UART receive path. It serialises one 5–8-bit character per request onto `tx`: start bit, data LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from the shared baud generator's 16x oversample tick. It sits between the register block (data, frame configuration, start and done handshake) and the pad. `cts_n` provides hardware flow control.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `tx_tick` pulses per bit period; the counter width is `$clog2(OVERSAMPLE)`.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `tx_tick`  in  1  one-`clk` pulse from the baud generator, OVERSAMPLE per bit
- `start_tx_i`  in  1  level request from the register block to send `tx_data_i`
- `tx_data_i`  in  32  character to send; only bits [N-1:0] are used, where N is the data width
- `data_bit_num_i`  in  2  data width select: 00=5, 01=6, 10=7, 11=8 bits
- `parity_en_i`  in  1  1 = append a parity bit
- `parity_type_i`  in  1  0 = odd parity (bit = ~^data), 1 = even parity (bit = ^data)
- `stop_bit_num_i`  in  1  0 = one stop bit, 1 = two stop bits
- `cts_n`  in  1  clear-to-send from the peer, active-low
- `tx`  out  1  serial line; idle high; registered
- `tx_busy_o`  out  1  high while a frame is in progress
- `tx_done_o`  out  1  one-`clk` pulse when the last stop bit completes

## Operation
- State machine states: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP.
- **Accept.** A request is accepted in TX_IDLE on any `clk` edge where `start_tx_i`=1 and `cts_n`=0. On that edge:
  - latch `tx_data_i[7:0]` into a shift register;
  - latch `data_bit_num_i`, `parity_en_i`, `parity_type_i` and `stop_bit_num_i`;
  - clear the tick counter and the bit counter;
  - compute parity over the latched N bits;
  - go to TX_START.
- **Ignored inputs.**
  - `start_tx_i` while not in TX_IDLE is ignored.
  - `cts_n` is sampled only at acceptance. Deasserting it mid-frame does not abort the frame.
  - Changes to configuration inputs or `tx_data_i` mid-frame have no effect on the current frame.
- **Tick counter.** It increments on each `tx_tick`. A bit ends on the `tx_tick` where the counter equals OVERSAMPLE-1; on that tick the counter wraps to 0 and the state advances. Each bit therefore lasts exactly OVERSAMPLE ticks.
- **Per-state behaviour:**
  - TX_START: `tx`=0. At bit end, go to TX_DATA.
  - TX_DATA: `tx` = shift register bit 0. At each bit end, shift right and increment the bit counter. After N bits, go to TX_PARITY if parity is enabled, otherwise TX_STOP.
  - TX_PARITY: `tx` = latched parity bit. At bit end, go to TX_STOP.
  - TX_STOP: `tx`=1. At the end of the 1st stop bit (1 stop configured) or the 2nd (2 stop configured), go to TX_IDLE and assert `tx_done_o`.
- **Frame length.** (1 + N + P + S) × OVERSAMPLE ticks, where P is 0/1 (parity) and S is 1/2 (stop bits).
- **Busy.** `tx_busy_o` is 1 in every state except TX_IDLE.
- **Back-to-back frames.** If `start_tx_i` is still high and `cts_n`=0 when the state machine returns to TX_IDLE, the next frame may be accepted on the following edge. The register block must drop `start_tx_i` on `tx_done_o` to send exactly one frame.

## Timing
- **Reset values.** `tx`=1, `tx_busy_o`=0, `tx_done_o`=0. State is TX_IDLE; counters and shift register are 0.
- **Reset mid-frame.** `tx` goes to 1 asynchronously and the frame is abandoned; no `tx_done_o` is generated.
- **Start bit.** `tx` falls on the `clk` edge after the acceptance edge, since `tx` is registered from state. `tx_busy_o` rises on the same edge.
- **Tick on the acceptance edge.** A `tx_tick` coinciding with the acceptance edge is not counted. The start bit spans the next OVERSAMPLE ticks.
- **Bit transitions.** Each `tx` change is registered one `clk` after the bit-end tick edge.
- **Done.** `tx_done_o` is high for exactly one `clk`, on the edge after the final stop-bit tick, coincident with `tx_busy_o` falling.
- **Earliest next frame.** The earliest next `tx` low is two `clk` after `tx_done_o` rises.
- **Gaps between ticks.** With `tx_tick`=0, all state, counters and `tx` hold.

## Test plan
- **8N1 send.** Config 8 data bits, no parity, 1 stop; send 0xA5 with `cts_n`=0. Required `tx` sequence, each bit 16 ticks: 0, 1,0,1,0,0,1,0,1, 1. Frame is 160 ticks; `tx_done_o` pulses once.
- **5-bit even parity.** Config 5 data bits, even parity (type=1), 1 stop; send 0x13. Required: data 1,1,0,0,1, parity 1, stop 1. With odd parity (type=0) the parity bit is 0.
- **7O2 send.** Config 7 data bits, odd parity, 2 stop; send 0x7F. Required: seven 1s, parity 0, then `tx`=1 for 32 ticks before `tx_done_o`. Frame is 176 ticks.
- **Flow control.** Hold `start_tx_i`=1 with `cts_n`=1 for 100 ticks: `tx` stays 1 and `tx_busy_o`=0. Drop `cts_n` to 0: the frame starts next `clk`. Raise `cts_n` mid-frame: the frame completes unchanged.
- **Mid-frame changes.** Change `data_bit_num_i`, `parity_en_i` and `tx_data_i` during TX_DATA: the current frame is unchanged. Pulse `start_tx_i` while busy: no extra frame is sent.
- **Reset mid-frame.** Assert `rst_n`=0 during TX_DATA: `tx`=1 and `tx_busy_o`=0 immediately, no `tx_done_o`. After release, a new 0x55 frame transmits correctly.
